// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle MIPS datapath (IR/A/B/ALUOut/MDR, shared memory).
// Define MULTICYCLE_PERF_CNT_EN to add the instr_count/cycle_count performance counters.
module multicycle_controller #(
    parameter int OPC_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opc,
    input  logic [OPC_W-1:0] func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWriteEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic [1:0]       RegDst,
    output logic [1:0]       DataToWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUoperation,
    output logic [1:0]       PCSrc
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] instr_count,
    output logic [PERF_W-1:0] cycle_count
`endif
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'b000011);
    localparam logic [OPC_W-1:0] OP_JR    = OPC_W'(6'b000110);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MRD = 4'd3,
        S_LWB    = 4'd4,  S_MWR    = 4'd5,  S_REX    = 4'd6,  S_RWB = 4'd7,
        S_BEQ    = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_J   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite, w_irWrite;
    logic       w_memToReg, w_regWrite, w_aluSrcA;
    logic [1:0] w_regDst, w_dataToWrite, w_aluSrcB, w_pcSrc;
    logic [2:0] w_aluOp, w_funcOp, w_immOp;

    function automatic logic [2:0] funcToAlu(input logic [OPC_W-1:0] f);
        case (f)
            OPC_W'(6'b100100): return ALU_AND;
            OPC_W'(6'b100101): return ALU_OR;
            OPC_W'(6'b100000): return ALU_ADD;
            OPC_W'(6'b100010): return ALU_SUB;
            OPC_W'(6'b101010): return ALU_SLT;
            default:           return ALU_AND;
        endcase
    endfunction

    assign w_funcOp = funcToAlu(func);
    assign w_immOp  = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_RTYPE:         w_next = S_REX;
                    OP_BEQ:           w_next = S_BEQ;
                    OP_ADDI, OP_SLTI: w_next = S_IEX;
                    OP_J:             w_next = S_J;
                    OP_JAL:           w_next = S_JAL;
                    OP_JR:            w_next = S_JR;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opc == OP_LW) ? S_MRD : ((opc == OP_SW) ? S_MWR : S_FETCH);
            S_MRD:    w_next = mem_ready ? S_LWB : S_MRD;
            S_MWR:    w_next = mem_ready ? S_FETCH : S_MWR;
            S_REX:    w_next = S_RWB;
            S_IEX:    w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Raw per-state controls; the write/request strobes are gated by reset below.
    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memToReg    = 1'b0;
        w_regDst      = 2'b00;
        w_dataToWrite = 2'b00;
        w_regWrite    = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_aluOp       = ALU_AND;
        w_pcSrc       = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                w_aluOp   = ALU_ADD;
                w_irWrite = mem_ready;
                w_pcWrite = mem_ready;
            end
            S_DECODE: begin
                w_aluSrcB = 2'b11;
                w_aluOp   = ALU_ADD;
            end
            S_MEMADR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_aluOp   = ALU_ADD;
            end
            S_MRD: begin
                w_iorD    = 1'b1;
                w_memRead = 1'b1;
            end
            S_LWB: begin
                w_memToReg = 1'b1;
                w_regWrite = 1'b1;
            end
            S_MWR: begin
                w_iorD     = 1'b1;
                w_memWrite = 1'b1;
            end
            S_REX: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = w_funcOp;
            end
            S_RWB: begin
                w_regDst   = 2'b01;
                w_regWrite = 1'b1;
                w_aluOp    = w_funcOp;
            end
            S_BEQ: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = ALU_SUB;
                w_pcSrc       = 2'b01;
                w_pcWriteCond = 1'b1;
            end
            S_IEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_aluOp   = w_immOp;
            end
            S_IWB: begin
                w_regWrite = 1'b1;
                w_aluOp    = w_immOp;
            end
            S_J: begin
                w_pcSrc   = 2'b10;
                w_pcWrite = 1'b1;
            end
            S_JAL: begin
                w_pcSrc       = 2'b10;
                w_pcWrite     = 1'b1;
                w_regDst      = 2'b10;
                w_dataToWrite = 2'b01;
                w_regWrite    = 1'b1;
            end
            S_JR: begin
                w_pcSrc   = 2'b11;
                w_pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWriteEn    = rst & (w_pcWrite | (w_pcWriteCond & zero));
    assign MemRead      = rst & w_memRead;
    assign MemWrite     = rst & w_memWrite;
    assign IRWrite      = rst & w_irWrite;
    assign RegWrite     = rst & w_regWrite;
    assign IorD         = w_iorD;
    assign MemToReg     = w_memToReg;
    assign RegDst       = w_regDst;
    assign DataToWrite  = w_dataToWrite;
    assign ALUSrcA      = w_aluSrcA;
    assign ALUSrcB      = w_aluSrcB;
    assign ALUoperation = w_aluOp;
    assign PCSrc        = w_pcSrc;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [PERF_W-1:0] r_instrCount;
    logic [PERF_W-1:0] r_cycleCount;

    // An instruction retires whenever the sequencer returns to fetch from any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instrCount <= '0;
            r_cycleCount <= '0;
        end else begin
            r_cycleCount <= r_cycleCount + PERF_W'(1);
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_instrCount <= r_instrCount + PERF_W'(1);
        end
    end

    assign instr_count = r_instrCount;
    assign cycle_count = r_cycleCount;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM sequencer for the multi-cycle MIPS datapath: shared instruction/data memory, single ALU, IR/A/B/ALUOut/MDR registers.
- Decodes the IR opcode and func fields into per-state datapath strobes.
- Stalls on a memory ready handshake.
- Instruction set: R-type (and/or/add/sub/slt), lw, sw, beq, addi, slti, j, jal, jr.

Parameters:
- OPC_W, 6, opcode and func field width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- opc  in  6  IR[31:26]; held stable by the datapath except on IRWrite.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWriteEn  out  1  PC load = PCWrite | (PCWriteCond & zero).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR and MDR.
- MemToReg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- RegDst  out  2  00 = rt, 01 = rd, 10 = r31.
- DataToWrite  out  2  00 = MemToReg path, 01 = PC (link).
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- ALUoperation  out  3  000 and, 001 or, 010 add, 011 sub, 111 slt.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.

Behaviour:
- State register: 4-bit, updated on posedge clk; rst low forces S_FETCH asynchronously.
- While rst is low, all write/request strobes are 0: MemRead, MemWrite, IRWrite, RegWrite, PCWriteEn.
- After reset release, all unlisted outputs are 0 in every state.
- Opcodes: RType 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010, jal 000011, jr 000110.
- R-type func codes: and 100100, or 100101, add 100000, sub 100010, slt 101010. Unknown func gives and (000).
- S_FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, op=add, PCSrc=00.
  - If mem_ready: IRWrite=1, PCWriteEn=1, go to S_DECODE. Else hold state (stall, no PC/IR change).
- S_DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, op=add (branch target into ALUOut).
  - Next state: lw/sw→S_MEMADR; RType→S_REX; beq→S_BEQ; addi/slti→S_IEX; j→S_J; jal→S_JAL; jr→S_JR.
  - Any other opcode → S_FETCH (executes as a nop, no writes).
- S_MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: lw→S_MRD, sw→S_MWR.
- S_MRD: IorD=1, MemRead=1, IRWrite=0 (MDR loads every cycle). Hold until mem_ready, then S_LWB.
- S_LWB: RegDst=00, MemToReg=1, RegWrite=1 → S_FETCH.
- S_MWR: IorD=1, MemWrite=1, held until mem_ready → S_FETCH. Exactly one MemWrite-with-ready cycle.
- S_REX: ALUSrcA=1, ALUSrcB=00, op from func → S_RWB.
- S_RWB: RegDst=01, RegWrite=1, op held from func → S_FETCH.
- S_BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWriteCond=1 → S_FETCH.
- S_IEX: ALUSrcA=1, ALUSrcB=10; op add for addi, slt for slti → S_IWB.
- S_IWB: RegDst=00, RegWrite=1, same op held → S_FETCH.
- S_J: PCSrc=10, PCWrite=1 → S_FETCH.
- S_JAL: PCSrc=10, PCWrite=1, RegDst=10, DataToWrite=01, RegWrite=1 → S_FETCH.
  - The register file captures the pre-update PC, which is already PC+4.
- S_JR: PCSrc=11, PCWrite=1 → S_FETCH.
- Latency in cycles, excluding memory waits: R-type 4, addi/slti 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Each memory state extends by one cycle per cycle mem_ready is low.
- mem_ready is ignored outside S_FETCH, S_MRD and S_MWR.
- Reset mid-instruction: the instruction is abandoned; no partial register or memory write is issued after rst falls.
- Unreachable state encodings → S_FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- When defined:
  - Adds outputs instr_count[PERF_W-1:0] and cycle_count[PERF_W-1:0], both reset to 0.
  - cycle_count increments every clock after reset.
  - instr_count increments on every transition into S_FETCH from a non-fetch state, including illegal-opcode nops.
  - Both counters wrap modulo 2^PERF_W.
- When undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: rst=0 for 3 cycles with mem_ready=1 → all strobes 0. First posedge after release: IRWrite=1, PCWriteEn=1.
- add R-type (opc=000000, func=100000), mem_ready=1 → states FETCH, DECODE, REX, RWB. ALUoperation=010 in REX. RegWrite=1 with RegDst=01 only in RWB.
- lw with mem_ready low for 2 cycles in S_MRD → S_MRD held 3 cycles total, MemRead=1 and IorD=1 throughout. Then S_LWB with MemToReg=1, RegWrite=1. 7 cycles total.
- beq: zero=1 → PCWriteEn=1, PCSrc=01 in S_BEQ. Repeat with zero=0 → PCWriteEn=0.
- jal → S_JAL asserts PCWrite, RegWrite, RegDst=10, DataToWrite=01 in one cycle. slti → ALUoperation=111 in S_IEX and S_IWB.
- Illegal opcode 111111 → DECODE→FETCH with no writes. Reset asserted in S_MWR → MemWrite drops immediately and the state is S_FETCH. With MULTICYCLE_PERF_CNT_EN: 5 instructions → instr_count=5.
